prog_loader_mem: RTL and testbench
==================================

Name: prog_loader_mem

Overview:
Instruction store and download engine for the washer controller core. Accepts a byte-serial program over a valid/ready stream and packs it into 32-bit instruction words. Checks the program with a checksum. Once the load is valid, it serves the core's instruction fetch combinationally from `pc`. Until then it presents the halt opcode, which keeps the core parked.

Parameters:
- INSTRS_WIDTH, 32, instruction word width (fixed at 4 bytes).
- ADDR_WIDTH, 8, width of `pc` and of the write address.
- DEPTH, 256, number of instruction words (at most 2**ADDR_WIDTH).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- pc, input, ADDR_WIDTH, fetch address from the core.
- instr, output, INSTRS_WIDTH, fetched instruction; combinational from `pc`.
- ld_start, input, 1, one-cycle pulse that begins or restarts a download.
- ld_valid, input, 1, byte strobe from the host.
- ld_data, input, 8, download byte.
- ld_last, input, 1, qualifies the final byte, which is the checksum byte.
- ld_ready, output, 1, loader accepts a byte this cycle.
- busy, output, 1, a load is in progress.
- done, output, 1, a valid program is resident.
- err, output, 1, the last load failed.

Behaviour:
- Reset: one clock, synchronous, active-low.
  - On reset, the state goes to IDLE and all counters and the checksum clear.
  - Reset values: `ld_ready`=0, `busy`=0, `done`=0, `err`=0, `instr`=0.
  - Memory contents are not reset; they are unreachable until the next DONE.
- States: IDLE, LOAD, DONE, ERR.
  - `busy`=1 only in LOAD.
  - `done`=1 only in DONE.
  - `err`=1 only in ERR.
  - `ld_ready`=1 only in LOAD.
- `ld_start` in any state, including LOAD:
  - Next state is LOAD.
  - `byte_idx`, `waddr`, `wcount` and `csum` clear.
  - Any byte offered in the same cycle is ignored.
- Byte transfer happens when `ld_valid & ld_ready`. On each transfer, `csum <= csum + ld_data` (mod 256).
- Data byte (`ld_last`=0):
  - Bytes pack little-endian: byte_idx 0 goes to bits [7:0], byte_idx 3 goes to bits [31:24].
  - The byte index increments and wraps 3->0.
  - On byte_idx=3, the full word is written to mem[`waddr`] in that cycle, `waddr` increments, and `wcount` increments.
- Overflow: a data byte accepted while `wcount`==DEPTH goes to ERR on the next cycle.
- Last byte (`ld_last`=1): the last byte is the checksum byte and is never stored. Next state is DONE iff all of the following hold; otherwise ERR:
  - the byte_idx is 0,
  - `wcount` >= 1,
  - `csum` + `ld_data` == 8'h00.
- Read path:
  - `instr` = mem[`pc`] when the state is DONE and `pc` < `wcount`.
  - `instr` = 32'h0 (halt opcode 8'h00) otherwise: in IDLE, LOAD and ERR, and for `pc` >= `wcount`.
  - The read is zero latency (asynchronous), because the core computes its next `pc` from `instr` in the same cycle.
- `wcount` persists in DONE and ERR until the next `ld_start` or reset.
- `ld_valid` outside LOAD has no effect.
- Reset mid-load: the state returns to IDLE. Words already written remain in memory but are not served.
- Width rules:
  - `waddr` is ADDR_WIDTH bits.
  - `wcount` is ADDR_WIDTH+1 bits, so a count of DEPTH is representable.
  - `byte_idx` is 2 bits.
  - `csum` is 8 bits, mod-256.

Decomposition:
- Shared package (used by the core too):
  - OP_HALT=8'h00,
  - the loader state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2, ERR=2'd3),
  - INSTR_BYTES=4.
- State, counter, checksum and holding registers all use the existing `dffr` flop cell with synchronous reset.
- One natural sub-module, `word_packer`:
  - contains the byte_idx counter and the 24-bit holding register,
  - outputs `word_valid` and `word` (32 bits) on the 4th byte,
  - is cleared by `ld_start`.
- The memory array and the FSM stay in the top module.

Test Plan:
1. Good load: `ld_start`, then bytes 21 01 03 00 00 00 00 00, then DB with `ld_last`. Expect `done`=1 and `wcount`=2. Then pc=0 gives `instr`=32'h0003_0121, pc=1 gives 32'h0, pc=5 gives 32'h0.
2. Bad checksum: same stream with last byte DA. Expect `err`=1, `done`=0, and `instr`=0 for pc=0.
3. Partial word: bytes 21 01 03, then `ld_last` with byte DB. Expect ERR because byte_idx != 0.
4. Overflow: with DEPTH=4, send 17 data bytes. Expect ERR after the 17th byte and `ld_ready`=0 after.
5. Restart and stall: during LOAD, after 5 bytes, pulse `ld_start`, then run the stream from scenario 1 with random `ld_valid` gaps. Expect DONE and word 0 = 32'h0003_0121.
6. Reset mid-load: deassert `rst_n` for one clk after 6 bytes. Expect IDLE next cycle with `busy`=0, `ld_ready`=0, `instr`=0. A following full load reaches DONE.

Source files
------------

// File: rtl/prog_loader_mem_pkg.sv
// Shared definitions for the program loader and the core that fetches from it.
package prog_loader_mem_pkg;
  localparam logic [7:0] OP_HALT     = 8'h00;
  localparam int         INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_e;
endpackage

// File: rtl/dffr.sv
// Flop cell with synchronous active-low reset to a parameterized value.
module dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end
endmodule

// File: rtl/prog_loader_mem_word_packer.sv
// Collects download bytes little-endian and presents a full word on the 4th byte.
module word_packer
  import prog_loader_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     byte_vld,
  input  logic [7:0]               byte_in,
  output logic [1:0]               byte_idx,
  output logic                     word_valid,
  output logic [INSTR_BYTES*8-1:0] word
);
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] hold_q, hold_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    hold_d     = hold_q;
    if (clr) begin
      byte_idx_d = '0;
      hold_d     = '0;
    end else if (byte_vld) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    hold_d[7:0]   = byte_in;
        2'd1:    hold_d[15:8]  = byte_in;
        2'd2:    hold_d[23:16] = byte_in;
        default: ;
      endcase
    end
  end

  // The top byte bypasses the holding register so the word is writable this cycle.
  assign word_valid = byte_vld && !clr && (byte_idx_q == 2'd3);
  assign word       = {byte_in, hold_q};
  assign byte_idx   = byte_idx_q;

  dffr #(.W(2))  u_idx  (.clk(clk), .rst_n(rst_n), .d(byte_idx_d), .q(byte_idx_q));
  dffr #(.W(24)) u_hold (.clk(clk), .rst_n(rst_n), .d(hold_d),     .q(hold_q));
endmodule

// File: rtl/prog_loader_mem.sv
// Byte-serial program download with checksum, plus the zero-latency fetch port.
module prog_loader_mem
  import prog_loader_mem_pkg::*;
#(
  parameter int INSTRS_WIDTH = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   pc,
  output logic [INSTRS_WIDTH-1:0] instr,
  input  logic                    ld_start,
  input  logic                    ld_valid,
  input  logic [7:0]              ld_data,
  input  logic                    ld_last,
  output logic                    ld_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [1:0]            state_raw_q, state_raw_d;
  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH:0]   wcount_q, wcount_d;
  logic [7:0]            csum_q, csum_d, csum_sum;
  logic                  xfer, data_xfer, full, last_ok, wr_en;
  logic [1:0]            byte_idx;
  logic                  word_valid;
  logic [31:0]           word;
  logic [31:0]           mem [DEPTH];

  assign state_q   = ld_state_e'(state_raw_q);
  assign state_raw_d = state_d;
  assign ld_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);

  // A start pulse wins over any byte offered in the same cycle.
  assign xfer      = ld_valid && ld_ready && !ld_start;
  assign data_xfer = xfer && !ld_last;
  assign full      = (wcount_q == FULL);
  assign csum_sum  = csum_q + ld_data;
  assign last_ok   = (byte_idx == 2'd0) && (wcount_q != '0) && (csum_sum == 8'h00);
  assign wr_en     = word_valid && !full;

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    wcount_d = wcount_q;
    csum_d   = csum_q;
    if (ld_start) begin
      state_d  = ST_LOAD;
      waddr_d  = '0;
      wcount_d = '0;
      csum_d   = '0;
    end else if (xfer) begin
      csum_d = csum_sum;
      if (ld_last)         state_d = last_ok ? ST_DONE : ST_ERR;
      else if (full)       state_d = ST_ERR;
      else if (word_valid) begin
        waddr_d  = waddr_q + 1'b1;
        wcount_d = wcount_q + 1'b1;
      end
    end
  end

  word_packer u_pack (
    .clk(clk), .rst_n(rst_n), .clr(ld_start), .byte_vld(data_xfer), .byte_in(ld_data),
    .byte_idx(byte_idx), .word_valid(word_valid), .word(word)
  );

  dffr #(.W(2))            u_state  (.clk(clk), .rst_n(rst_n), .d(state_raw_d), .q(state_raw_q));
  dffr #(.W(ADDR_WIDTH))   u_waddr  (.clk(clk), .rst_n(rst_n), .d(waddr_d),     .q(waddr_q));
  dffr #(.W(ADDR_WIDTH+1)) u_wcount (.clk(clk), .rst_n(rst_n), .d(wcount_d),    .q(wcount_q));
  dffr #(.W(8))            u_csum   (.clk(clk), .rst_n(rst_n), .d(csum_d),      .q(csum_q));

  // Storage is deliberately not reset; it is only visible once a load completes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr_q[MW-1:0]] <= word;
  end

  always_comb begin
    instr = {{(INSTRS_WIDTH-8){1'b0}}, OP_HALT};
    if (done && ({1'b0, pc} < wcount_q)) instr = INSTRS_WIDTH'(mem[pc[MW-1:0]]);
  end
endmodule

// File: tb/tb_prog_loader_mem.sv
// Randomized and directed checks of the loader against a queue-based program model.
module tb_prog_loader_mem;
  localparam int DEPTH = 4;
  typedef logic [7:0] byte_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc;
  logic [31:0] instr;
  logic        ld_start, ld_valid, ld_last, ld_ready, busy, done, err;
  logic [7:0]  ld_data;

  int n_chk = 0;
  int n_err = 0;

  prog_loader_mem #(.INSTRS_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    ld_valid = $urandom_range(0, 1) == 1;  // must be ignored
    ld_data  = 8'hFF;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic send_byte(input byte_t b, input logic last, input int gap_pct);
    for (int g = 0; g < 3; g++) begin
      if ($urandom_range(0, 99) >= gap_pct) break;
      ld_valid = 1'b0;
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Expected outcome of a whole download: data bytes then a checksum byte.
  task automatic check_result(input string tag, input byte_t d[$], input byte_t lastb);
    int    nd, nw;
    byte_t sum;
    logic  ok;
    logic [31:0] exp_w;
    nd  = d.size();
    sum = lastb;
    foreach (d[i]) sum = sum + d[i];
    ok  = (nd <= 4 * DEPTH) && (nd % 4 == 0) && (nd >= 4) && (sum == 8'h00);
    nw  = ok ? nd / 4 : 0;
    chk({tag, ".done"},  {31'b0, done},     {31'b0, ok});
    chk({tag, ".err"},   {31'b0, err},      {31'b0, !ok});
    chk({tag, ".busy"},  {31'b0, busy},     32'd0);
    chk({tag, ".ready"}, {31'b0, ld_ready}, 32'd0);
    for (int p = 0; p < 8; p++) begin
      pc = 8'(p);
      #1;
      exp_w = 32'h0;
      if (p < nw) exp_w = {d[4*p+3], d[4*p+2], d[4*p+1], d[4*p]};
      chk($sformatf("%s.instr[%0d]", tag, p), instr, exp_w);
    end
    pc = 8'h00;
  endtask

  task automatic run_prog(input string tag, input byte_t d[$], input byte_t lastb, input int gap_pct);
    pulse_start();
    chk({tag, ".busy0"}, {31'b0, busy}, 32'd1);
    foreach (d[i]) send_byte(d[i], 1'b0, gap_pct);
    send_byte(lastb, 1'b1, gap_pct);
    check_result(tag, d, lastb);
  endtask

  function automatic byte_t csum_of(input byte_t d[$]);
    byte_t s = 8'h00;
    foreach (d[i]) s = s + d[i];
    return 8'h00 - s;
  endfunction

  initial begin
    byte_t prog1[$];
    byte_t q[$];
    byte_t lb;
    int    nd;
    prog1 = '{8'h21, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0; pc = 8'h00; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    tick();
    chk("rst.ready", {31'b0, ld_ready}, 32'd0);
    chk("rst.busy",  {31'b0, busy},     32'd0);
    chk("rst.done",  {31'b0, done},     32'd0);
    chk("rst.err",   {31'b0, err},      32'd0);
    chk("rst.instr", instr,             32'h0);
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_data = 8'h55;   // no effect outside LOAD
    tick();
    ld_valid = 1'b0;
    chk("idle.busy", {31'b0, busy}, 32'd0);

    // good load, then bad checksum, then partial word
    run_prog("good", prog1, 8'hDB, 0);
    run_prog("badcs", prog1, 8'hDA, 0);
    q = '{8'h21, 8'h01, 8'h03};
    run_prog("partial", q, 8'hDB, 0);

    // overflow: 17 data bytes into a 4-word store
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0, 0);
    chk("ovf.busy16", {31'b0, busy}, 32'd1);
    send_byte(8'h11, 1'b0, 0);
    chk("ovf.err",   {31'b0, err},      32'd1);
    chk("ovf.ready", {31'b0, ld_ready}, 32'd0);
    chk("ovf.instr", instr,             32'h0);

    // restart mid-load, then full stream with stalls
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0, 0);
    run_prog("restart", prog1, 8'hDB, 50);

    // reset mid-load
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 1'b0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid.busy",  {31'b0, busy},     32'd0);
    chk("rstmid.ready", {31'b0, ld_ready}, 32'd0);
    chk("rstmid.done",  {31'b0, done},     32'd0);
    chk("rstmid.instr", instr,             32'h0);
    run_prog("afterrst", prog1, 8'hDB, 0);

    // randomized programs: sizes straddle the word boundary and the capacity
    for (int it = 0; it < 24; it++) begin
      q.delete();
      case ($urandom_range(0, 3))
        0:       nd = 4 * $urandom_range(1, DEPTH);
        1:       nd = $urandom_range(0, 4 * DEPTH);
        2:       nd = 4 * DEPTH + $urandom_range(1, 3);
        default: nd = 4 * $urandom_range(1, DEPTH);
      endcase
      for (int i = 0; i < nd; i++) q.push_back(8'($urandom));
      lb = csum_of(q);
      if ($urandom_range(0, 3) == 0) lb = lb ^ 8'(1 << $urandom_range(0, 7));
      run_prog($sformatf("rnd%0d", it), q, lb, $urandom_range(0, 60));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
